battle_input_ctrl: RTL
======================

BATTLE_INPUT_CTRL -- requirements
Module: battle_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, number of consecutive stable clk cycles required before a button level is accepted.
REQ-002 Parameter SCAN_DIV, default 1000, number of clk cycles per column scan slot.
REQ-003 clk  input  1  sole clock, rising-edge; one clock domain.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 btn_up, btn_down, btn_left, btn_right, btn_fire  input  1 each  raw asynchronous push-buttons, active-high.
REQ-006 count0, count1, count2  output  1 each  column scan index, count0 = LSB.
REQ-007 row0, row1, row2  output  1 each  cursor row, row0 = LSB.
REQ-008 col0, col1, col2  output  1 each  cursor column, col0 = LSB.
REQ-009 fire  output  1  shot request to the downstream board stage, active-high.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 The debounced level SHALL change only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-012 A debounced 0->1 transition SHALL produce a one-cycle press event; release produces no event.
REQ-013 The scan prescaler SHALL count 0..SCAN_DIV-1; at terminal it wraps to 0 and the scan index advances by 1, wrapping 7->0.
REQ-014 Cursor row/col SHALL be 3-bit registers: down = row+1, up = row-1, right = col+1, left = col-1, all modulo 8 (7->0, 0->7).
REQ-015 Press events on up and down in the same cycle SHALL leave row unchanged; likewise left+right for col; row and col events in the same cycle SHALL both apply.
REQ-016 Cursor updates SHALL take effect on the clk edge after the press event (1-cycle latency) and only in state IDLE; moves in other states are discarded.
REQ-017 Fire FSM states: IDLE, ARM, FIRE, LOCK.
REQ-018 IDLE -> ARM on fire press event.
REQ-019 ARM -> FIRE on the cycle the scan index advances to a value equal to col, so FIRE is aligned to a full slot.
REQ-020 FIRE -> LOCK when that slot ends (prescaler terminal); FIRE lasts exactly SCAN_DIV cycles.
REQ-021 LOCK -> IDLE when the debounced fire level is 0; a held button SHALL NOT refire.
REQ-022 Output fire SHALL be registered and equal 1 exactly while state is FIRE.
REQ-023 Fire press events outside IDLE SHALL be ignored.

Reset
REQ-024 On rst: all outputs 0, scan index 0, prescaler 0, cursor (0,0), state IDLE, synchronizers, debounced levels and debounce counters 0.
REQ-025 rst mid-operation (any state) SHALL abort the shot; fire is 0 from the first edge with rst high.

Structure
REQ-026 Package battle_pkg SHALL hold the fire FSM state enum, GRID_W = 3, GRID_MAX = 7.
REQ-027 One sub-module battle_debounce (synchronizer + debouncer + press pulse, parameter DEBOUNCE_CYCLES) SHALL be instantiated five times.

Verification (DEBOUNCE_CYCLES=4, SCAN_DIV=4)
REQ-028 rst held 3 cycles, released -> all outputs 0; scan index steps 0,1,...,7,0 every 4 cycles.
REQ-029 btn_right held 10 cycles from cursor (0,7) -> col wraps to 0, exactly one step; btn_up from row 0 -> row 7.
REQ-030 btn_down toggled every 2 cycles for 20 cycles then released -> row unchanged; up+down pressed same cycle -> row unchanged.
REQ-031 Cursor col=5, btn_fire pressed -> fire high for exactly 4 cycles, all while scan index = 5; btn_right during ARM/FIRE -> col stays 5.
REQ-032 btn_fire held 100 cycles -> one FIRE window only; after release plus 4-cycle debounce, a new press fires again.
REQ-033 rst asserted in second cycle of FIRE -> fire 0 at next edge, state IDLE, cursor (0,0).

Source files
------------

// File: rtl/battle_pkg.sv
// Shared types and constants for the battle input controller.
// Holds the fire FSM state enum, the cursor grid size, the button indices
// and a modulo-8 step helper used by the cursor and the scan index.
package battle_pkg;

  localparam int GRID_W   = 3;
  localparam int GRID_MAX = 7;

  localparam int NUM_BTNS  = 5;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_FIRE  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    FIRE = 2'd2,
    LOCK = 2'd3
  } fire_state_e;

  // Moves a grid coordinate by +1 or -1 with wraparound. Opposite
  // requests in the same cycle cancel, so the value is left alone.
  function automatic logic [GRID_W-1:0] wrap_step(input logic [GRID_W-1:0] v,
                                                  input logic inc,
                                                  input logic dec);
    logic [GRID_W-1:0] r;
    r = v;
    if (inc && !dec) begin
      r = (v == GRID_W'(GRID_MAX)) ? '0 : v + GRID_W'(1);
    end else if (dec && !inc) begin
      r = (v == '0) ? GRID_W'(GRID_MAX) : v - GRID_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/battle_debounce.sv
// Per-button conditioning: a two-flop synchronizer, a stability counter that
// accepts a new level only after it has held for DEBOUNCE_CYCLES cycles, and
// a single-cycle press pulse on each accepted rising level.
module battle_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive disagreeing cycles; any agreement restarts the count.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Register the synchronizer, debounced level, counter and press pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/battle_input_ctrl.sv
// Battle game input controller: debounces five buttons, steps a column scan
// index, moves a wrapping 8x8 cursor, and issues a shot request that lasts
// exactly one full scan slot on the column under the cursor.
module battle_input_ctrl
  import battle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SCAN_DIV        = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_fire,
  output logic count0,
  output logic count1,
  output logic count2,
  output logic row0,
  output logic row1,
  output logic row2,
  output logic col0,
  output logic col1,
  output logic col2,
  output logic fire
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] btn_press;
  logic                unused_levels;

  logic [PW-1:0]     pre_q, pre_d;
  logic [GRID_W-1:0] scan_q, scan_d;
  logic [GRID_W-1:0] row_q, row_d;
  logic [GRID_W-1:0] col_q, col_d;
  fire_state_e       state_q, state_d;
  logic              fire_q, fire_d;
  logic              scan_adv;

  assign btn_raw = {btn_fire, btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    battle_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i])
    );
  end

  // Only the fire level matters (to release LOCK); move buttons act on presses.
  assign unused_levels = ^btn_level[BTN_FIRE-1:0];

  // Prescaler wraps every SCAN_DIV cycles and advances the scan index then.
  always_comb begin
    scan_adv = (pre_q == PRE_LAST);
    pre_d    = scan_adv ? '0 : pre_q + PW'(1);
    scan_d   = wrap_step(scan_q, scan_adv, 1'b0);
  end

  // Fire FSM and cursor; the cursor only moves while no shot is in progress.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        row_d = wrap_step(row_q, btn_press[BTN_DOWN], btn_press[BTN_UP]);
        col_d = wrap_step(col_q, btn_press[BTN_RIGHT], btn_press[BTN_LEFT]);
        if (btn_press[BTN_FIRE]) state_d = ARM;
      end
      ARM:     if (scan_adv && (scan_d == col_q)) state_d = FIRE;
      FIRE:    if (scan_adv) state_d = LOCK;
      LOCK:    if (!btn_level[BTN_FIRE]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    fire_d = (state_d == FIRE);
  end

  // State registers; reset aborts any shot and homes the cursor.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      scan_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      state_q <= IDLE;
      fire_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      scan_q  <= scan_d;
      row_q   <= row_d;
      col_q   <= col_d;
      state_q <= state_d;
      fire_q  <= fire_d;
    end
  end

  assign {count2, count1, count0} = scan_q;
  assign {row2, row1, row0}       = row_q;
  assign {col2, col1, col0}       = col_q;
  assign fire                     = fire_q;

endmodule
